// File: rtl/lsu_subword_rmw.sv
// rtl/lsu_subword_rmw.sv - load/store unit with sub-word read-modify-write for a word-only data memory
// Optional feature: define LSU_MISALIGN_EXC_EN to report misaligned halfword/word accesses as errors.
module lsu_subword_rmw #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LD     = 3'd1;
    localparam logic [2:0] S_ST     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [2:0]            state;
    logic [2:0]            cap_funct3;
    logic [ADDR_WIDTH+1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic [31:0]           merge_q;

    logic                  req_illegal;
    logic                  req_misaligned;
    logic                  req_err;
    logic [31:0]           load_fmt;
    logic [31:0]           merge_word;

    // Only the word-address bits reach the memory; upper address bits wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (state == S_IDLE) && !rst;

    always_comb begin
        req_illegal = 1'b0;
        if (req_we) begin
            req_illegal = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
        end else begin
            req_illegal = !(req_funct3 == F3_B  || req_funct3 == F3_H || req_funct3 == F3_W ||
                            req_funct3 == F3_BU || req_funct3 == F3_HU);
        end
    end

    always_comb begin
        req_misaligned = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
        if (req_funct3[1:0] == 2'b01) begin
            req_misaligned = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            req_misaligned = |req_addr[1:0];
        end
`endif
    end

    assign req_err = req_illegal || req_misaligned;

    // Lane selection ignores the low address bits a halfword/word access does not use,
    // which is what silently aligns misaligned accesses when they are not reported.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b   = mem_rdata[{cap_addr[1:0], 3'b000} +: 8];
        lane_h   = cap_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_fmt = 32'd0;
        case (cap_funct3)
            F3_B:    load_fmt = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_fmt = {{16{lane_h[15]}}, lane_h};
            F3_W:    load_fmt = mem_rdata;
            F3_BU:   load_fmt = {24'd0, lane_b};
            F3_HU:   load_fmt = {16'd0, lane_h};
            default: load_fmt = 32'd0;
        endcase
    end

    always_comb begin
        merge_word = merge_q;
        if (cap_funct3 == F3_B) begin
            merge_word[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
        end else if (cap_addr[1]) begin
            merge_word[31:16] = cap_wdata[15:0];
        end else begin
            merge_word[15:0] = cap_wdata[15:0];
        end
    end

    // Reset gating keeps an interrupted RMW from committing a write in the reset cycle.
    assign mem_read  = !rst && (state == S_LD || state == S_RMW_RD);
    assign mem_write = !rst && (state == S_ST || state == S_RMW_WR);
    assign mem_addr  = cap_addr[ADDR_WIDTH+1:2];

    always_comb begin
        mem_wdata = 32'd0;
        if (mem_write) begin
            mem_wdata = (state == S_ST) ? cap_wdata : merge_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cap_funct3 <= 3'd0;
            cap_addr   <= '0;
            cap_wdata  <= 32'd0;
            merge_q    <= 32'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr[ADDR_WIDTH+1:0];
                        cap_wdata  <= req_wdata;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (!req_we) begin
                            state <= S_LD;
                        end else if (req_funct3 == F3_W) begin
                            state <= S_ST;
                        end else begin
                            state <= S_RMW_RD;
                        end
                    end
                end
                S_LD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_fmt;
                    state      <= S_IDLE;
                end
                S_ST: begin
                    resp_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                S_RMW_RD: begin
                    merge_q <= mem_rdata;
                    state   <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    resp_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// tb/tb_lsu_subword_rmw.sv - self-checking bench for lsu_subword_rmw against a byte-level reference model
module tb_lsu_subword_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] dmem    [64];
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    lsu_subword_rmw #(.ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Word memory without byte enables; a poison value stands in for the undriven bus.
    assign mem_rdata = mem_read ? dmem[mem_addr] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_write) dmem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                         output int lat, output int nrd, output int nwr);
        int size, off, idx;
        logic [31:0] w;
        bit legal, mis;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis   = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
        mis = (addr % size) != 0;
`endif
        idx   = int'(addr[7:2]);
        off   = (int'(addr[1:0]) / size) * size;
        err   = !legal || mis;
        rdata = 32'd0;
        nrd   = 0;
        nwr   = 0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            nrd = 1;
            w = ref_mem[idx] >> (8 * off);
            if (size < 4) begin
                w = w % (32'd1 << (8 * size));
                if (!f3[2] && w >= (32'd1 << (8 * size - 1))) w = w - (32'd1 << (8 * size));
            end
            rdata = w;
        end else begin
            lat = (size == 4) ? 2 : 3;
            nwr = 1;
            nrd = (size == 4) ? 0 : 1;
            for (int k = 0; k < size; k++) ref_mem[idx][8 * (off + k) +: 8] = wdata[8 * k +: 8];
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat, e_rd, e_wr;
        int          n, nrd, nwr, both, lat;
        logic [5:0]  waddr;
        logic        ready_at_resp;
        model(we, f3, addr, wdata, e_err, e_rdata, e_lat, e_rd, e_wr);
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        nrd = 0; nwr = 0; both = 0; lat = 0; waddr = 6'd0; ready_at_resp = 1'b0;
        got = 32'hFFFF_FFFF;
        for (n = 1; n <= 6 && lat == 0; n++) begin
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; waddr = mem_addr; end
            if (mem_read && mem_write) both++;
            if (resp_valid) begin
                lat = n;
                got = resp_rdata;
                ready_at_resp = req_ready;
                chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e_err});
                chk({tag, "_rdata"}, resp_rdata, e_rdata);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_nreads"}, nrd, e_rd);
        chk({tag, "_nwrites"}, nwr, e_wr);
        chk({tag, "_overlap"}, both, 0);
        chk({tag, "_ready_at_resp"}, {31'd0, ready_at_resp}, 32'd1);
        if (e_wr != 0) chk({tag, "_waddr"}, {26'd0, waddr}, {26'd0, addr[7:2]});
        @(posedge clk); #1;
        chk({tag, "_one_pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [2:0]  f3;
        for (int i = 0; i < 64; i++) begin dmem[i] = 32'd0; ref_mem[i] = 32'd0; end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_outs", {27'd0, resp_valid, resp_err, mem_read, mem_write, 1'b0}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_maddr", {26'd0, mem_addr}, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got);
        do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, got);
        chk("tp_lw10", got, 32'hDEADBEEF);

        do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, got);
        do_req("sb22", 1'b1, 3'b000, 32'h22, 32'h000000AB, got);
        do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, got);
        chk("tp_sb_merge", got, 32'h11AB3344);

        do_req("sw00", 1'b1, 3'b010, 32'h0, 32'h8000FF80, got);
        do_req("lb0", 1'b0, 3'b000, 32'h0, 32'h0, got);  chk("tp_lb", got, 32'hFFFFFF80);
        do_req("lbu0", 1'b0, 3'b100, 32'h0, 32'h0, got); chk("tp_lbu", got, 32'h00000080);
        do_req("lh2", 1'b0, 3'b001, 32'h2, 32'h0, got);  chk("tp_lh", got, 32'hFFFF8000);
        do_req("lhu2", 1'b0, 3'b101, 32'h2, 32'h0, got); chk("tp_lhu", got, 32'h00008000);

        do_req("ld011", 1'b0, 3'b011, 32'h0, 32'h0, got);
        do_req("st100", 1'b1, 3'b100, 32'h8, 32'h12345678, got);

        do_req("sw04", 1'b1, 3'b010, 32'h4, 32'hCAFE1234, got);
        do_req("lh5", 1'b0, 3'b001, 32'h5, 32'h0, got);
`ifndef LSU_MISALIGN_EXC_EN
        chk("tp_lh5_aligned", got, 32'h00001234);
`endif
        do_req("sh7", 1'b1, 3'b001, 32'h7, 32'h0000BEEF, got);
        do_req("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FF04, 32'h0, got);

        // Reset lands in the RMW_RD cycle of an SH; nothing may be written or answered.
        do_req("sw30", 1'b1, 3'b010, 32'h30, 32'h11223344, got);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h30; req_wdata = 32'h5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #0;
        chk("rmw_rst_nowrite", {31'd0, mem_write}, 32'd0);
        chk("rmw_rst_noresp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #0;
        chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rmw_rst_idle", {29'd0, resp_valid, mem_write, mem_read}, 32'd0);
        @(posedge clk); #1;
        chk("rmw_rst_quiet", {29'd0, resp_valid, mem_write, mem_read}, 32'd0);
        do_req("lw30", 1'b0, 3'b010, 32'h30, 32'h0, got);
        chk("tp_rst_word", got, 32'h11223344);

        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            do_req("rnd", 1'($urandom), f3, $urandom, $urandom, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
